// File: rtl/opacc_pkg.sv
// Shared definitions for the outer-product accumulator: controller state encoding
// and helpers that derive row/column counts from the bit-level vector lengths.
package opacc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_C = 2'd1,
        ST_ACC    = 2'd2
    } state_e;

    function automatic int calc_vl(input int vlen, input int xlen);
        return vlen / xlen;
    endfunction

    function automatic int calc_ml(input int mlen, input int xlen);
        return mlen / xlen;
    endfunction

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/opacc_shift_fsm.sv
// Controller for the accumulator: sequences an ML-cycle column load of C and then
// gates operand beats into the multiply-accumulate array.
module shift_fsm
    import opacc_pkg::*;
#(
    parameter int ML = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic c_valid,
    input  logic ab_valid,
    output logic en_c,
    output logic en_ab
);

    localparam int CW = cnt_width(ML);
    localparam logic [CW-1:0] LAST_CNT = CW'(ML - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ab_valid has no back-pressure: a beat is consumed on any edge where en_ab is 1,
    // and beats offered while en_ab is 0 (IDLE, LOAD_C) are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_c    = (state_q == ST_LOAD_C);
        en_ab   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (c_valid) begin
                    state_d = ST_LOAD_C;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_C: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_ACC;
                    cnt_d   = '0;
                end
            end
            ST_ACC: begin
                en_ab = ab_valid;
                if (c_valid) begin
                    state_d = ST_LOAD_C;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/opacc.sv
// Outer-product accumulator: C[i][j] += a_i * b_j over a VL x ML register array,
// with a column shifter that loads a new C while streaming the old one out of column 0.
module opacc_top
    import opacc_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int VLEN  = 128,
    parameter int MLEN  = 128,
    localparam int VL   = calc_vl(VLEN, XLEN),
    localparam int ML   = calc_ml(MLEN, XLEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c_valid,
    input  logic               ab_valid,
    input  logic               issng_a,
    input  logic               issng_b,
    input  logic [VL*XLEN-1:0] vi_a,
    input  logic [ML*XLEN-1:0] vi_b,
    input  logic [VL*XLEN-1:0] vi_c,
    output logic [VL*XLEN-1:0] vo_c,
    output logic               en_c,
    output logic               en_ab
);

    logic [XLEN-1:0]   c_q [VL][ML];
    logic [XLEN-1:0]   c_d [VL][ML];
    logic [2*XLEN-1:0] a_ext [VL];
    logic [2*XLEN-1:0] b_ext [ML];

    shift_fsm #(
        .ML (ML)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .c_valid  (c_valid),
        .ab_valid (ab_valid),
        .en_c     (en_c),
        .en_ab    (en_ab)
    );

    always_comb begin
        for (int i = 0; i < VL; i++) begin
            a_ext[i] = {{XLEN{issng_a & vi_a[i*XLEN + XLEN - 1]}}, vi_a[i*XLEN +: XLEN]};
        end
        for (int j = 0; j < ML; j++) begin
            b_ext[j] = {{XLEN{issng_b & vi_b[j*XLEN + XLEN - 1]}}, vi_b[j*XLEN +: XLEN]};
        end
    end

    // Shift wins over accumulate; sums wrap at XLEN bits.
    always_comb begin
        for (int i = 0; i < VL; i++) begin
            for (int j = 0; j < ML; j++) begin
                c_d[i][j] = c_q[i][j];
                if (en_c) begin
                    c_d[i][j] = (j == ML - 1) ? vi_c[i*XLEN +: XLEN] : c_q[i][(j + 1) % ML];
                end else if (en_ab) begin
                    c_d[i][j] = c_q[i][j] + XLEN'(a_ext[i] * b_ext[j]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VL; i++) begin
                for (int j = 0; j < ML; j++) begin
                    c_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < VL; i++) begin
                for (int j = 0; j < ML; j++) begin
                    c_q[i][j] <= c_d[i][j];
                end
            end
        end
    end

    always_comb begin
        vo_c = '0;
        for (int i = 0; i < VL; i++) begin
            vo_c[i*XLEN +: XLEN] = c_q[i][0];
        end
    end

endmodule

// File: tb/tb_opacc_top.sv
// Directed bench for opacc_top at XLEN=64, VL=ML=2: load, accumulate, wrap, signed,
// shift-out during reload, priority of the load request and asynchronous reset.
module tb_opacc_top;
    import opacc_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         c_valid, ab_valid, issng_a, issng_b;
    logic [127:0] vi_a, vi_b, vi_c, vo_c;
    logic         en_c, en_ab;

    int checks = 0;
    int passes = 0;

    logic [63:0] exp_c [2][2];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    opacc_top #(
        .XLEN (64),
        .VLEN (128),
        .MLEN (128)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_valid  (c_valid),
        .ab_valid (ab_valid),
        .issng_a  (issng_a),
        .issng_b  (issng_b),
        .vi_a     (vi_a),
        .vi_b     (vi_b),
        .vi_c     (vi_c),
        .vo_c     (vo_c),
        .en_c     (en_c),
        .en_ab    (en_ab)
    );

    function automatic logic [127:0] pack(input logic [63:0] e0, input logic [63:0] e1);
        return {e1, e0};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_exp(input logic [63:0] c00, input logic [63:0] c01,
                           input logic [63:0] c10, input logic [63:0] c11);
        exp_c[0][0] = c00;
        exp_c[0][1] = c01;
        exp_c[1][0] = c10;
        exp_c[1][1] = c11;
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check($sformatf("%s_c%0d%0d", tag, i, j), 128'(dut.c_q[i][j]), 128'(exp_c[i][j]));
            end
        end
        check({tag, "_vo_c"}, vo_c, pack(exp_c[0][0], exp_c[1][0]));
    endtask

    task automatic check_state(input string tag, input state_e st);
        check(tag, 128'(dut.u_fsm.state_q), 128'(st));
    endtask

    // Loads C column by column; also checks the old C streams out of vo_c meanwhile.
    task automatic load(input string tag, input logic [63:0] m00, input logic [63:0] m01,
                        input logic [63:0] m10, input logic [63:0] m11, input bit hold_cv);
        logic [127:0] old0, old1;
        old0 = pack(exp_c[0][0], exp_c[1][0]);
        old1 = pack(exp_c[0][1], exp_c[1][1]);
        @(negedge clk);
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = hold_cv;
        vi_c    = pack(m00, m10);
        #1;
        check({tag, "_en_c1"}, 128'(en_c), 128'(1'b1));
        check({tag, "_en_ab1"}, 128'(en_ab), 128'(1'b0));
        check({tag, "_out_col0"}, vo_c, old0);
        @(negedge clk);
        c_valid = 1'b0;
        vi_c    = pack(m01, m11);
        #1;
        check({tag, "_en_c2"}, 128'(en_c), 128'(1'b1));
        check({tag, "_out_col1"}, vo_c, old1);
        @(negedge clk);
        vi_c = '0;
        #1;
        check({tag, "_en_c_done"}, 128'(en_c), 128'(1'b0));
        check_state({tag, "_st_acc"}, ST_ACC);
        set_exp(m00, m01, m10, m11);
        check_c(tag);
    endtask

    task automatic beat(input string tag, input logic [63:0] a0, input logic [63:0] a1,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input logic sa, input logic sb);
        @(negedge clk);
        ab_valid = 1'b1;
        vi_a     = pack(a0, a1);
        vi_b     = pack(b0, b1);
        issng_a  = sa;
        issng_b  = sb;
        #1;
        check({tag, "_en_ab"}, 128'(en_ab), 128'(1'b1));
        check({tag, "_en_c"}, 128'(en_c), 128'(1'b0));
        @(negedge clk);
        ab_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        c_valid  = 1'b0;
        ab_valid = 1'b0;
        issng_a  = 1'b0;
        issng_b  = 1'b0;
        vi_a     = '0;
        vi_b     = '0;
        vi_c     = '0;
        set_exp(0, 0, 0, 0);
        #3;
        check("rst_en_c", 128'(en_c), 128'(1'b0));
        check("rst_en_ab", 128'(en_ab), 128'(1'b0));
        check("rst_vo_c", vo_c, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_state("rst_idle", ST_IDLE);

        // Operand beats in IDLE are not accepted.
        @(negedge clk);
        ab_valid = 1'b1;
        vi_a     = pack(1, 1);
        vi_b     = pack(1, 1);
        #1;
        check("idle_en_ab", 128'(en_ab), 128'(1'b0));
        @(negedge clk);
        ab_valid = 1'b0;
        #1;
        check_state("idle_stay", ST_IDLE);
        check_c("idle_no_acc");

        // c_valid held into LOAD_C must not restart the load.
        load("load1", 64'd0, 64'd0, 64'd0, 64'd1, 1'b1);

        repeat (3) begin
            @(negedge clk);
            #1;
            check("acc_idle_en_ab", 128'(en_ab), 128'(1'b0));
            check_state("acc_idle_st", ST_ACC);
        end
        check_c("acc_idle_hold");

        load("load_zero", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

        beat("mac1", 64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b0);
        set_exp(64'd3, 64'd4, 64'd6, 64'd8);
        check_c("mac1");
        beat("mac2", 64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b0);
        set_exp(64'd6, 64'd8, 64'd12, 64'd16);
        check_c("mac2");

        load("load_ones", ONES, ONES, ONES, ONES, 1'b0);
        beat("wrap", 64'd1, 64'd1, 64'd1, 64'd1, 1'b0, 1'b0);
        set_exp(0, 0, 0, 0);
        check_c("wrap");

        beat("signed", ONES, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
        set_exp(64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd6, 64'hFFFF_FFFF_FFFF_FFF8);
        check_c("signed");

        // c_valid together with a beat in ACC: the beat lands, then LOAD_C masks ab_valid.
        @(negedge clk);
        c_valid  = 1'b1;
        ab_valid = 1'b1;
        vi_a     = pack(1, 0);
        vi_b     = pack(1, 0);
        issng_a  = 1'b0;
        issng_b  = 1'b0;
        #1;
        check("cv_ab_en_ab", 128'(en_ab), 128'(1'b1));
        check("cv_ab_en_c", 128'(en_c), 128'(1'b0));
        @(negedge clk);
        c_valid = 1'b0;
        vi_c    = pack(64'd5, 64'd7);
        #1;
        check("ld_ab_en_ab1", 128'(en_ab), 128'(1'b0));
        check("ld_ab_en_c1", 128'(en_c), 128'(1'b1));
        check("ld_ab_out0", vo_c, pack(64'hFFFF_FFFF_FFFF_FFFE, 64'd6));
        @(negedge clk);
        vi_c = pack(64'd9, 64'd11);
        #1;
        check("ld_ab_en_ab2", 128'(en_ab), 128'(1'b0));
        check("ld_ab_en_c2", 128'(en_c), 128'(1'b1));
        check("ld_ab_out1", vo_c, pack(64'd4, 64'hFFFF_FFFF_FFFF_FFF8));
        @(negedge clk);
        ab_valid = 1'b0;
        vi_c     = '0;
        #1;
        set_exp(64'd5, 64'd9, 64'd7, 64'd11);
        check_c("ld_ab");

        // Asynchronous reset in the middle of ACC, between clock edges.
        @(negedge clk);
        ab_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_acc_en_ab", 128'(en_ab), 128'(1'b0));
        check("arst_acc_en_c", 128'(en_c), 128'(1'b0));
        check_state("arst_acc_st", ST_IDLE);
        set_exp(0, 0, 0, 0);
        check_c("arst_acc");
        @(negedge clk);
        ab_valid = 1'b0;
        reset    = 1'b1;

        // Asynchronous reset in the middle of LOAD_C.
        @(negedge clk);
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        vi_c    = pack(64'd3, 64'd3);
        @(negedge clk);
        vi_c = pack(64'd4, 64'd4);
        #2;
        check("arst_ld_pre_en_c", 128'(en_c), 128'(1'b1));
        reset = 1'b0;
        #1;
        check("arst_ld_en_c", 128'(en_c), 128'(1'b0));
        check_state("arst_ld_st", ST_IDLE);
        check_c("arst_ld");

        // First edge after release behaves as IDLE.
        @(negedge clk);
        reset    = 1'b1;
        ab_valid = 1'b1;
        vi_a     = pack(1, 1);
        vi_b     = pack(1, 1);
        @(negedge clk);
        #1;
        check_state("post_rst_idle", ST_IDLE);
        check("post_rst_en_ab", 128'(en_ab), 128'(1'b0));
        check_c("post_rst");
        ab_valid = 1'b0;
        c_valid  = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        #1;
        check("post_rst_load", 128'(en_c), 128'(1'b1));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/opacc_top.md
OPACC_TOP -- requirements
Module: opacc_top

Interface
REQ-001 Parameter XLEN, default 64, element width in bits.
REQ-002 Parameter VLEN, default 128, A/C column vector length in bits; VL = VLEN/XLEN rows.
REQ-003 Parameter MLEN, default 128, B vector length in bits; ML = MLEN/XLEN columns.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 c_valid  input  1  request to load the C accumulator (one-cycle pulse sufficient).
REQ-007 ab_valid  input  1  A/B operand beat valid for accumulation.
REQ-008 issng_a  input  1  1 = A elements signed, 0 = unsigned.
REQ-009 issng_b  input  1  1 = B elements signed, 0 = unsigned.
REQ-010 vi_a  input  VL*XLEN  A column vector; element i at bits [i*XLEN +: XLEN].
REQ-011 vi_b  input  ML*XLEN  B row vector; element j at bits [j*XLEN +: XLEN].
REQ-012 vi_c  input  VL*XLEN  C column shifted in during load; element i = row i.
REQ-013 vo_c  output  VL*XLEN  C column 0 (vo_c element i = C[i][0]).
REQ-014 en_c  output  1  C load/shift enable (FSM status).
REQ-015 en_ab  output  1  accumulate enable (FSM status).

Function
REQ-016 Accumulator C SHALL be VL x ML registers of XLEN bits, C[i][j].
REQ-017 FSM states SHALL be IDLE, LOAD_C, ACC; encoding free.
REQ-018 IDLE: c_valid=1 -> LOAD_C with load counter cleared; else stay.
REQ-019 LOAD_C: en_c=1 for exactly ML consecutive cycles, counter increments per cycle; after the ML-th cycle -> ACC; c_valid ignored in LOAD_C.
REQ-020 ACC: en_ab = ab_valid (combinational); c_valid=1 -> LOAD_C next cycle (en_ab forced 0 in that cycle's successor); otherwise stay.
REQ-021 en_c SHALL be a decode of state (registered, no input path); en_c and en_ab SHALL never be 1 together.
REQ-022 en_c=1 edge: for each row i, C[i][j] <= C[i][j+1] for j<ML-1, C[i][ML-1] <= vi_c[i]; after ML load cycles the first loaded column sits in column 0.
REQ-023 vo_c SHALL continuously present column 0, so a reload simultaneously shifts out the previous C one column per cycle.
REQ-024 en_ab=1 edge: C[i][j] <= C[i][j] + low XLEN bits of (a_i * b_j), a_i/b_j extended to 2*XLEN per issng_a/issng_b.
REQ-025 Addition SHALL wrap modulo 2^XLEN, no saturation, no overflow flag.
REQ-026 Neither enable: C holds.
REQ-027 If both enables were ever asserted on the datapath, en_c SHALL take priority.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, counter 0, all C[i][j]=0, hence vo_c=0, en_c=0, en_ab=0, regardless of clock, including mid-LOAD_C or mid-ACC.
REQ-029 After release, first rising edge SHALL behave as IDLE.

Structure
REQ-030 Shared package SHALL hold the FSM state enumeration and the derived VL/ML computation helpers.
REQ-031 Controller SHALL be sub-module shift_fsm (params ML; ports clk, reset, c_valid, ab_valid, en_c, en_ab); datapath (C array, shifter, VL*ML multiply-accumulate) in opacc_top.

Verification (XLEN=64, VLEN=MLEN=128, VL=ML=2)
REQ-032 Reset asserted mid-operation -> en_c=0, en_ab=0, all C=0, vo_c=0 without a clock edge.
REQ-033 c_valid one-cycle pulse in IDLE, vi_c={0,0} then {0,1} -> en_c=1 exactly 2 cycles, then C[0]={0,0}, C[1]={0,1}, state ACC; second c_valid during LOAD_C has no effect.
REQ-034 C=0, ab_valid=1, A={1,2}, B={3,4}, two beats -> C after beat 1 = {{3,4},{6,8}}, after beat 2 = {{6,8},{12,16}}.
REQ-035 C all 0xFFFF_FFFF_FFFF_FFFF, A={1,1}, B={1,1}, one beat -> all C=0 (wrap).
REQ-036 issng_a=issng_b=1, A={-1,2}, B={3,-4}, C=0 -> C={{-3,4},{6,-8}} (two's complement 64-bit).
REQ-037 ACC with ab_valid=0 for 3 cycles -> en_ab=0, C unchanged; then c_valid -> vo_c shows old column 0 then old column 1 while new C loads.
